circuit_b: RTL and testbench

Three-input odd-parity (full-adder sum) logic block. The combinational output `f` equals `x ^ y ^ z`. Alongside it sit a one-cycle registered copy and an optional saturating count of cycles where `f` is high. It serves as a small leaf function inside the lab datapath, where downstream logic uses either the combinational or the registered result.

---
 rtl/circuit_b_pkg.sv | 12 +
 rtl/circuit_b_parity3.sv | 13 +
 rtl/circuit_b.sv | 47 ++++
 tb/tb_circuit_b.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/circuit_b_pkg.sv
// Shared definitions for circuit_b: the default counter width, the counter type,
// and the three-input odd-parity truth table indexed by {x,y,z}.
package circuit_b_pkg;

    localparam int CIRCUIT_B_CNT_W = 8;

    typedef logic [CIRCUIT_B_CNT_W-1:0] cnt_t;

    // Bit {x,y,z} holds x ^ y ^ z.
    localparam logic [7:0] CIRCUIT_B_TT = 8'b1001_0110;

endpackage

// File: rtl/circuit_b_parity3.sv
// parity3: combinational three-input odd parity (full-adder sum).
// X/Z on any input propagates straight through the XOR tree.
module parity3 (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic f
);

    // Odd parity of the three operand bits.
    assign f = x ^ y ^ z;

endmodule

// File: rtl/circuit_b.sv
// circuit_b: odd-parity leaf with a registered copy and an optional
// saturating count of cycles where the parity is high.
// Optional feature macro: CIRCUIT_B_CNT_EN adds ones_cnt / cnt_sat.
module circuit_b
    import circuit_b_pkg::*;
#(
    parameter int CNT_W = CIRCUIT_B_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             y,
    input  logic             z,
    output logic             f,
    output logic             f_q
`ifdef CIRCUIT_B_CNT_EN
    ,
    output logic [CNT_W-1:0] ones_cnt,
    output logic             cnt_sat
`endif
);

    parity3 u_parity3 (
        .x (x),
        .y (y),
        .z (z),
        .f (f)
    );

    // One-cycle registered copy of the parity result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) f_q <= 1'b0;
        else     f_q <= f;
    end

`ifdef CIRCUIT_B_CNT_EN
    // Saturation flag is decoded straight from the counter value.
    assign cnt_sat = (ones_cnt == {CNT_W{1'b1}});

    // Count sampled cycles with f high; hold at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                ones_cnt <= '0;
        else if (f && !cnt_sat) ones_cnt <= ones_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_circuit_b.sv
// Directed bench for circuit_b with a scoreboard queue of expected register state.
module tb_circuit_b;
    import circuit_b_pkg::*;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst = 1'b1;
    logic x = 1'b0, y = 1'b0, z = 1'b0;
    logic f, f_q;
`ifdef CIRCUIT_B_CNT_EN
    logic [CW-1:0] ones_cnt;
    logic          cnt_sat;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          fq;
        logic [CW-1:0] cnt;
        logic          sat;
    } exp_t;

    exp_t          sb[$];
    logic [7:0]    tt;
    logic          fq_m;
    logic [CW-1:0] cnt_m;

`ifdef CIRCUIT_B_CNT_EN
    circuit_b #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .z(z),
        .f(f), .f_q(f_q), .ones_cnt(ones_cnt), .cnt_sat(cnt_sat)
    );
`else
    circuit_b dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .z(z),
        .f(f), .f_q(f_q)
    );
`endif

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fq_m  = 1'b0;
        cnt_m = '0;
    endtask

    // Check the registered state against the reset values.
    task automatic chk_reset_state(input string tag);
        chk({tag, "_fq"}, 16'(f_q), 16'(0));
`ifdef CIRCUIT_B_CNT_EN
        chk({tag, "_cnt"}, 16'(ones_cnt), 16'(0));
        chk({tag, "_sat"}, 16'(cnt_sat), 16'(0));
`endif
    endtask

    // Drive one operand triple, push the expected post-edge state, then
    // pop and compare after the edge.
    task automatic step(input string tag, input logic [2:0] v);
        exp_t e;
        exp_t got;
        {x, y, z} = v;
        #1;
        chk({tag, "_f"}, 16'(f), 16'(tt[v]));
        fq_m = tt[v];
        if (tt[v] && cnt_m != {CW{1'b1}}) cnt_m = cnt_m + 1'b1;
        e.fq  = fq_m;
        e.cnt = cnt_m;
        e.sat = (cnt_m == {CW{1'b1}});
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 16'(1), 16'(0));
        end else begin
            got = sb.pop_front();
            chk({tag, "_fq"}, 16'(f_q), 16'(got.fq));
`ifdef CIRCUIT_B_CNT_EN
            chk({tag, "_cnt"}, 16'(ones_cnt), 16'(got.cnt));
            chk({tag, "_sat"}, 16'(cnt_sat), 16'(got.sat));
`endif
        end
    endtask

    initial begin
        tt = CIRCUIT_B_TT;
        model_reset();

        // Combinational sweep under reset, clock stopped.
        for (int v = 0; v < 8; v++) begin
            {x, y, z} = 3'(v);
            #1;
            chk("sweep_f", 16'(f), 16'(tt[v]));
        end
        chk_reset_state("rst_hold");

        // Start the clock with reset still asserted, then release between edges.
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_state("rst_edge");
        rst = 1'b0;

        // Registered path.
        step("reg001", 3'b001);
        step("reg011", 3'b011);

        // Counting: 5 ones then 3 zeros.
        rst = 1'b1; #1; rst = 1'b0; model_reset();
        chk_reset_state("cnt_rst");
        for (int i = 0; i < 5; i++) step("cnt111", 3'b111);
        for (int i = 0; i < 3; i++) step("cnt110", 3'b110);

        // Saturation: 20 cycles with f high.
        rst = 1'b1; #1; rst = 1'b0; model_reset();
        for (int i = 0; i < 20; i++) step("sat100", 3'b100);

        // Asynchronous reset mid-run.
        rst = 1'b1; #1; rst = 1'b0; model_reset();
        for (int i = 0; i < 7; i++) step("pre010", 3'b010);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_state("async");
        chk("async_f", 16'(f), 16'(1));
        #1;
        rst = 1'b0;
        model_reset();
        step("resume", 3'b010);
        step("resume", 3'b000);
        step("resume", 3'b111);

        chk("sb_drained", 16'(sb.size()), 16'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Overall time bound so the run can never hang.
    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

endmodule
